// File: rtl/button_conditioner.sv
// Push-button conditioning: two-flop synchroniser, per-channel debouncer and
// per-channel auto-repeat FSM producing level, press and release outputs.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic                   clk25MHz,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] button_raw,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TW   = $clog2(TMAX);

  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TMR_ONE     = TW'(1);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_HOLD_DELAY  = 2'd1,
    ST_HOLD_REPEAT = 2'd2
  } state_e;

  logic [NUM_BUTTONS-1:0] meta_q;
  logic [NUM_BUTTONS-1:0] sync_q;

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= button_raw;
      sync_q <= meta_q;
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rise_s, fall_s;

    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_q[g] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        stable_d = sync_q[g];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Edges are taken from the next stable value so the pulse registers
    // alongside the level change rather than one cycle behind it.
    assign rise_s = stable_d & ~stable_q;
    assign fall_s = ~stable_d & stable_q;

    always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (fall_s) begin
        release_d = 1'b1;
        state_d   = ST_RELEASED;
        timer_d   = '0;
      end else begin
        case (state_q)
          ST_RELEASED: begin
            timer_d = '0;
            if (rise_s) begin
              press_d = 1'b1;
              if (REPEAT_EN != 0) begin
                state_d = ST_HOLD_DELAY;
              end else begin
                state_d = ST_HOLD_REPEAT;
              end
            end else begin
              state_d = ST_RELEASED;
            end
          end
          ST_HOLD_DELAY: begin
            if (timer_q == DELAY_LAST) begin
              press_d = 1'b1;
              timer_d = '0;
              state_d = ST_HOLD_REPEAT;
            end else begin
              timer_d = timer_q + TMR_ONE;
            end
          end
          ST_HOLD_REPEAT: begin
            if (REPEAT_EN == 0) begin
              timer_d = timer_q;
            end else if (timer_q == PERIOD_LAST) begin
              press_d = 1'b1;
              timer_d = '0;
            end else begin
              timer_d = timer_q + TMR_ONE;
            end
          end
          default: begin
            state_d = ST_RELEASED;
            timer_d = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk25MHz or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        stable_q  <= 1'b0;
        state_q   <= ST_RELEASED;
        timer_q   <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        stable_q  <= stable_d;
        state_q   <= state_d;
        timer_q   <= timer_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign button_level[g]   = stable_q;
    assign button_press[g]   = press_q;
    assign button_release[g] = release_q;
  end

endmodule
